// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit counter width: $clog2 of the word width, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts a word on load && ready and shifts it out
// one bit per clock on w, with gapless back-to-back words when load is held.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_d, w_valid_d, done_d;
    logic             accept;

    // Ready comes from registers only, so an upstream load can never loop back into it.
    assign ready  = (state_q == IDLE) || (state_q == SHIFT && cnt_q == '0);
    assign accept = load && ready;

    // Next-state, shift and output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        w_d       = w;
        w_valid_d = w_valid;
        done_d    = 1'b0;

        if (accept) begin
            // First bit goes straight to w; the rest wait in the shift register.
            w_d       = LSB_FIRST ? data[0] : data[WIDTH-1];
            sreg_d    = LSB_FIRST ? (data >> 1) : (data << 1);
            cnt_d     = CNT_LAST;
            w_valid_d = 1'b1;
            state_d   = SHIFT;
            // Accepting while the last bit of a word is on w closes that word.
            done_d    = (state_q == SHIFT);
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                w_d    = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
                sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
                cnt_d  = cnt_q - 1'b1;
            end else begin
                w_d       = 1'b0;
                w_valid_d = 1'b0;
                state_d   = IDLE;
                done_d    = 1'b1;
            end
        end else begin
            w_d       = 1'b0;
            w_valid_d = 1'b0;
        end
    end

    // State, datapath and registered outputs; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values computed above, independent of statement order.
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            w       <= w_d;
            w_valid <= w_valid_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed scenarios plus randomized
// traffic checked against a queue-based model of the serial stream.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       load = 1'b0;
    logic [7:0] data = '0;
    logic       ready, w, w_valid, done;

    logic       load4 = 1'b0;
    logic [3:0] data4 = '0;
    logic       ready4, w4, w_valid4, done4;

    int checks = 0;
    int errors = 0;

    // Reference model for the 8-bit MSB-first instance: bits still to come
    // after the one currently on w, plus whether a word is on the line.
    bit m_q[$];
    bit m_busy = 1'b0;
    bit m_cur  = 1'b0;
    bit m_done = 1'b0;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .ready(ready), .w(w), .w_valid(w_valid), .done(done)
    );

    bit_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .load(load4), .data(data4),
        .ready(ready4), .w(w4), .w_valid(w_valid4), .done(done4)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return !m_busy || (m_q.size() == 0);
    endfunction

    function automatic bit m_w();
        return m_busy ? m_cur : 1'b0;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_cur  = 1'b0;
        m_done = 1'b0;
    endtask

    // One clock: decide acceptance from pre-edge inputs, advance the model,
    // then settle 1 time unit past the edge so outputs can be sampled.
    task automatic step();
        bit acc;
        acc = load && m_ready();
        @(posedge clk);
        if (!rst) begin
            m_reset();
        end else begin
            m_done = m_busy && (m_q.size() == 0);
            if (acc) begin
                m_q.delete();
                for (int i = 0; i < 8; i++) m_q.push_back(data[7-i]);
                m_cur  = m_q.pop_front();
                m_busy = 1'b1;
            end else if (m_busy && m_q.size() > 0) begin
                m_cur = m_q.pop_front();
            end else begin
                m_busy = 1'b0;
                m_cur  = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        load = 1'b1;
        data = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({w, w_valid, done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got w/w_valid/done=%b%b%b want 000", c, w, w_valid, done);
            end
        end
        rst  = 1'b1;
        load = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b/%b want 1/1", ready, ready4);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] got;
        load = 1'b1;
        data = 8'b0110_1001;
        step();
        load = 1'b0;
        data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            got[7-i] = w;
            checks++;
            if (w_valid !== 1'b1 || done !== 1'b0 || ready !== (i == 7)) begin
                errors++;
                $display("FAIL single_bit%0d got w_valid/done/ready=%b%b%b want 10%b",
                         i, w_valid, done, ready, (i == 7));
            end
            if (i < 7) step();
        end
        checks++;
        if (got !== 8'b0110_1001) begin
            errors++;
            $display("FAIL single_bits got %b want 01101001", got);
        end
        step();
        checks++;
        if ({w, w_valid, done, ready} !== 4'b0011) begin
            errors++;
            $display("FAIL single_end got w/w_valid/done/ready=%b%b%b%b want 0011", w, w_valid, done, ready);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        load = 1'b1;
        data = 8'hA5;
        step();
        for (int c = 1; c <= 17; c++) begin
            if (c <= 16) got[16-c] = w;
            checks++;
            if (w_valid !== (c <= 16) || done !== (c == 9 || c == 17)) begin
                errors++;
                $display("FAIL b2b_cyc%0d got w_valid/done=%b%b want %b%b",
                         c, w_valid, done, (c <= 16), (c == 9 || c == 17));
            end
            if (c == 8) data = 8'h3C;
            if (c == 9) load = 1'b0;
            if (c < 17) step();
        end
        checks++;
        if (got !== 16'hA53C) begin
            errors++;
            $display("FAIL b2b_bits got %h want a53c", got);
        end
        step();
    endtask

    task automatic test_load_while_busy();
        int dones = 0;
        load = 1'b1;
        data = 8'h00;
        step();
        load = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (done) dones++;
            checks++;
            if (w !== m_w() || w_valid !== m_busy || done !== m_done || ready !== m_ready() || w !== 1'b0) begin
                errors++;
                $display("FAIL busy_cyc%0d got w/v/d/r=%b%b%b%b want %b%b%b%b",
                         c, w, w_valid, done, ready, 1'b0, m_busy, m_done, m_ready());
            end
            load = (c == 3);
            data = (c == 3) ? 8'hFF : 8'h00;
            step();
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_done_count got %0d want 1", dones);
        end
        step();
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] got;
        load = 1'b1;
        data = 8'hF0;
        step();
        load = 1'b0;
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({w, w_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_async got w/w_valid/done=%b%b%b want 000", w, w_valid, done);
        end
        step();
        rst = 1'b1;
        checks++;
        if ({w, w_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_hold got w/w_valid/done=%b%b%b want 000", w, w_valid, done);
        end
        load = 1'b1;
        data = 8'h81;
        step();
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) got[7-i] = w;
            checks++;
            if (w !== m_w() || w_valid !== m_busy || done !== m_done || ready !== m_ready()) begin
                errors++;
                $display("FAIL rst_mid_next%0d got w/v/d/r=%b%b%b%b want %b%b%b%b",
                         i, w, w_valid, done, ready, m_w(), m_busy, m_done, m_ready());
            end
            step();
        end
        checks++;
        if (got !== 8'h81) begin
            errors++;
            $display("FAIL rst_mid_bits got %b want 10000001", got);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            load = ($urandom_range(0, 3) != 0);
            data = 8'($urandom);
            step();
            checks++;
            if (w !== m_w() || w_valid !== m_busy || done !== m_done || ready !== m_ready()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cyc%0d got w/v/d/r=%b%b%b%b want %b%b%b%b",
                             c, w, w_valid, done, ready, m_w(), m_busy, m_done, m_ready());
            end
        end
        load = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_lsb_first();
        bit exp_bits[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        load4 = 1'b1;
        data4 = 4'b0011;
        step();
        load4 = 1'b0;
        data4 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w4 !== exp_bits[i] || w_valid4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL lsb_bit%0d got w/w_valid/done=%b%b%b want %b10",
                         i, w4, w_valid4, done4, exp_bits[i]);
            end
            step();
        end
        checks++;
        if ({w4, w_valid4, done4, ready4} !== 4'b0011) begin
            errors++;
            $display("FAIL lsb_end got w/w_valid/done/ready=%b%b%b%b want 0011", w4, w_valid4, done4, ready4);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_word();
        test_random();
        test_lsb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
